maj7_tt_sweeper: RTL and testbench
==================================

Name: maj7_tt_sweeper

Overview:
Controller that sequences a shared 7-input Boolean evaluator, typically a majority-gate network with fixed pipeline latency, across all 128 input minterms. It captures the 128-bit truth table and its onset count for the classification flow. Sits between the classification scheduler (start/result handshake) and one evaluator instance (issue/return ports). One sweep at a time; the evaluator is not shared with other requesters while busy.

Parameters:
EVAL_LAT, 2, fixed evaluator latency in cycles from eval_x issue to eval_f valid; legal 0..8 (0 = combinational evaluator)
NIN, 7, evaluator input count; fixed at 7, checked by elaboration assertion

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  sweep request pulse; accepted only in IDLE
abort  in  1  synchronous sweep cancel
busy  out  1  high from start acceptance until return to IDLE
eval_vld  out  1  eval_x carries a minterm this cycle
eval_x  out  7  minterm index driven to evaluator (x0 = bit 0)
eval_f  in  1  evaluator output, valid EVAL_LAT cycles after matching eval_vld
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_tt  out  128  truth table; bit i = f(minterm i)
res_ones  out  8  onset count, 0..128
exp_tt  in  128  expected truth table (optional feature)
res_mismatch  out  1  res_tt differs from exp_tt (optional feature)
res_first_bad  out  7  lowest mismatching minterm (optional feature)

Behaviour:
- Reset: state IDLE; busy, eval_vld, res_valid, res_mismatch = 0; eval_x, res_tt, res_ones, res_first_bad = 0; index counter and capture pipe cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> ISSUE, busy=1, res_tt/res_ones cleared. start while not in IDLE is ignored; start is not queued.
- ISSUE: eval_vld=1 and eval_x=idx, with idx = 0,1,...,127 on consecutive cycles and no gaps. After idx 127 is issued, go to DRAIN. If EVAL_LAT=0, go straight to DONE.
- Capture: a valid/index delay line of depth EVAL_LAT tags each return. On a tagged return, res_tt[tag] <= eval_f and res_ones increments when eval_f=1. Capture is independent of state.
- DRAIN: eval_vld=0, eval_x=0. Go to DONE when the tag-127 capture happens.
- Timing: res_valid rises exactly 128+EVAL_LAT rising edges after the edge that sampled start.
- DONE: res_valid=1. res_tt, res_ones and mismatch outputs hold stable until res_valid && res_ready. On that cycle go to IDLE, with busy=0 and res_valid=0 at the next edge. Outputs keep their last values in IDLE.
- abort=1 in ISSUE/DRAIN/DONE: next state IDLE, busy=0, res_valid=0, eval_vld=0. Captures still in flight are discarded. abort has priority over start and res_ready.
- eval_x is 0 whenever eval_vld=0.
- res_ones is 8 bits and cannot overflow (maximum 128 = 8'h80).
- Asynchronous reset mid-sweep aborts with no result. No retained state.

Optional Feature:
Macro TT_EXPECT_CMP_EN.
- Defined: exp_tt is registered on start acceptance. Each capture compares against the registered bit. res_mismatch is set on the first difference, and res_first_bad records the lowest differing index; captures arrive in index order, so the first difference is the lowest. Both are valid with res_valid.
- Undefined: exp_tt is ignored. res_mismatch and res_first_bad are constant 0, and the comparator and registers are not synthesized.

Decomposition:
- Shared package maj7_pkg holds:
  - state enum (IDLE/ISSUE/DRAIN/DONE)
  - NUM_MINTERMS=128, IDX_W=7, ONES_W=8
  - EVAL_LAT_MAX=8
  - truth-table typedef tt_t (logic [127:0])
- One sub-module: maj7_lat_tag, the EVAL_LAT-deep valid+index delay line. Its depth-0 case is a pass-through.

Test Plan:
- Evaluator f=maj(x0,x1,x2), EVAL_LAT=2, start pulse -> eval_x sweeps 0..127 on consecutive cycles; res_valid 130 edges after start; res_tt = 0xE8 repeated over 16 bytes; res_ones=64.
- f=const 1 (EVAL_LAT=0) -> res_tt all ones, res_ones=8'h80. f=const 0 -> res_tt=0, res_ones=0.
- f=x6, EVAL_LAT=8, res_ready held low 20 cycles -> res_tt=0xFFFFFFFFFFFFFFFF_0000000000000000; outputs stable for all 20 cycles; IDLE the edge after res_ready.
- start re-pulsed during ISSUE and abort asserted at idx 50 -> no res_valid; busy low next cycle. A fresh start then produces a correct full sweep.
- rst_n low at idx 90 -> all outputs 0 asynchronously; eval_vld=0.
- TT_EXPECT_CMP_EN defined, f=maj(x0,x1,x2), exp_tt equal to the correct table except bits 5 and 77 flipped -> res_mismatch=1, res_first_bad=5. With exp_tt exactly correct -> res_mismatch=0.

Source files
------------

// File: rtl/maj7_pkg.sv
// maj7_pkg: shared types and sizes for the 7-input truth-table sweeper.
package maj7_pkg;

  localparam int unsigned NUM_MINTERMS = 128;
  localparam int unsigned IDX_W        = 7;
  localparam int unsigned ONES_W       = 8;
  localparam int unsigned EVAL_LAT_MAX = 8;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MINTERMS - 1);

  typedef logic [NUM_MINTERMS-1:0] tt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Issue tag carried alongside the evaluator pipeline.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/maj7_lat_tag.sv
// maj7_lat_tag: DEPTH-deep valid+index delay line aligning issue tags with evaluator returns.
module maj7_lat_tag
  import maj7_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  tag_t in_tag,
  output tag_t out_tag
);

  if (DEPTH == 0) begin : g_pass
    // Combinational evaluator: the return belongs to the minterm issued this cycle.
    logic unused_lat0;
    assign unused_lat0 = clk ^ rst_n ^ flush;
    assign out_tag     = in_tag;
  end else begin : g_pipe
    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];

    always_comb begin
      pipe_d[0] = in_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          pipe_d[i] = '0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign out_tag = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/maj7_tt_sweeper.sv
// maj7_tt_sweeper: sweeps a 7-input evaluator over all 128 minterms, capturing truth table and onset count.
// Expected-table comparison (res_mismatch/res_first_bad) is built only when TT_EXPECT_CMP_EN is defined.
module maj7_tt_sweeper
  import maj7_pkg::*;
#(
  parameter int unsigned EVAL_LAT = 2,
  parameter int unsigned NIN      = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    eval_vld,
  output logic [IDX_W-1:0]        eval_x,
  input  logic                    eval_f,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NUM_MINTERMS-1:0] res_tt,
  output logic [ONES_W-1:0]       res_ones,
  input  logic [NUM_MINTERMS-1:0] exp_tt,
  output logic                    res_mismatch,
  output logic [IDX_W-1:0]        res_first_bad
);

  if (NIN != IDX_W) begin : g_bad_nin
    $error("maj7_tt_sweeper: NIN must be 7");
  end
  if (EVAL_LAT > EVAL_LAT_MAX) begin : g_bad_lat
    $error("maj7_tt_sweeper: EVAL_LAT must be 0..8");
  end

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               eval_vld_q, eval_vld_d;
  logic [IDX_W-1:0]   eval_x_q, eval_x_d;
  logic               res_valid_q, res_valid_d;
  tt_t                res_tt_q, res_tt_d;
  logic [ONES_W-1:0]  res_ones_q, res_ones_d;

  tag_t issue_tag;
  tag_t ret_tag;
  logic accept_c;
  logic cap_c;
  logic cap_last_c;

  assign issue_tag  = '{vld: eval_vld_q, idx: eval_x_q};
  assign accept_c   = (state_q == ST_IDLE) && start;
  // Abort discards the return arriving in the same cycle as well as those still in flight.
  assign cap_c      = ret_tag.vld && !abort;
  assign cap_last_c = cap_c && (ret_tag.idx == IDX_LAST);

  maj7_lat_tag #(
    .DEPTH (EVAL_LAT)
  ) u_lat_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .in_tag  (issue_tag),
    .out_tag (ret_tag)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE is entered on the capture of minterm 127, whatever the latency.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (abort)                       state_d = ST_IDLE;
        else if (cap_last_c)             state_d = ST_DONE;
        else if (eval_x_q == IDX_LAST)   state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)           state_d = ST_IDLE;
        else if (cap_last_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort || res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and capture next values
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
    eval_vld_d  = (state_d == ST_ISSUE);
    eval_x_d    = '0;
    res_tt_d    = res_tt_q;
    res_ones_d  = res_ones_q;

    if ((state_d == ST_ISSUE) && (state_q == ST_ISSUE)) begin
      eval_x_d = IDX_W'(eval_x_q + IDX_W'(1));
    end

    if (accept_c) begin
      res_tt_d   = '0;
      res_ones_d = '0;
    end else if (cap_c) begin
      res_tt_d[ret_tag.idx] = eval_f;
      res_ones_d            = ONES_W'(res_ones_q + ONES_W'(eval_f));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      eval_vld_q  <= 1'b0;
      eval_x_q    <= '0;
      res_valid_q <= 1'b0;
      res_tt_q    <= '0;
      res_ones_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      eval_vld_q  <= eval_vld_d;
      eval_x_q    <= eval_x_d;
      res_valid_q <= res_valid_d;
      res_tt_q    <= res_tt_d;
      res_ones_q  <= res_ones_d;
    end
  end

  assign busy      = busy_q;
  assign eval_vld  = eval_vld_q;
  assign eval_x    = eval_x_q;
  assign res_valid = res_valid_q;
  assign res_tt    = res_tt_q;
  assign res_ones  = res_ones_q;

`ifdef TT_EXPECT_CMP_EN
  tt_t              exp_q, exp_d;
  logic             mis_q, mis_d;
  logic [IDX_W-1:0] first_bad_q, first_bad_d;

  // Captures arrive in index order, so the first difference seen is the lowest one.
  always_comb begin
    exp_d       = exp_q;
    mis_d       = mis_q;
    first_bad_d = first_bad_q;
    if (accept_c) begin
      exp_d       = exp_tt;
      mis_d       = 1'b0;
      first_bad_d = '0;
    end else if (cap_c && !mis_q && (eval_f != exp_q[ret_tag.idx])) begin
      mis_d       = 1'b1;
      first_bad_d = ret_tag.idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q       <= '0;
      mis_q       <= 1'b0;
      first_bad_q <= '0;
    end else begin
      exp_q       <= exp_d;
      mis_q       <= mis_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign res_mismatch  = mis_q;
  assign res_first_bad = first_bad_q;
`else
  logic unused_exp;
  assign unused_exp    = ^exp_tt;
  assign res_mismatch  = 1'b0;
  assign res_first_bad = '0;
`endif

endmodule

// File: tb/tb_maj7_tt_sweeper.sv
// tb_maj7_tt_sweeper: directed sweeps at latencies 2, 0 and 8 with a result scoreboard.
module tb_maj7_tt_sweeper;

  localparam int NI = 3;
  localparam int unsigned LAT_TAB [NI] = '{2, 0, 8};

  localparam logic [1:0] F_MAJ  = 2'd0;
  localparam logic [1:0] F_ONE  = 2'd1;
  localparam logic [1:0] F_ZERO = 2'd2;
  localparam logic [1:0] F_X6   = 2'd3;

  localparam logic [127:0] TT_MAJ = {16{8'hE8}};
  localparam logic [127:0] TT_ONE = {128{1'b1}};
  localparam logic [127:0] TT_X6  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

  typedef struct {
    int           inst;
    logic [127:0] tt;
    logic [7:0]   ones;
    logic         mis;
    logic [6:0]   fb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]        start, abort, res_ready;
  logic [NI-1:0]        busy, eval_vld, eval_f, res_valid, res_mismatch;
  logic [NI-1:0][6:0]   eval_x, res_first_bad;
  logic [NI-1:0][127:0] res_tt;
  logic [NI-1:0][7:0]   res_ones;
  logic [127:0]         exp_tt;
  logic [1:0]           fsel;

  int n_pass  = 0;
  int n_total = 0;
  exp_t sb_q[$];
  logic [NI-1:0] rv_prev = '0;

  always #5 clk = ~clk;

  function automatic logic f_model(input logic [1:0] s, input logic [6:0] x);
    case (s)
      F_MAJ:   return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      F_ONE:   return 1'b1;
      F_ZERO:  return 1'b0;
      default: return x[6];
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = LAT_TAB[g];
    logic fnow;
    assign fnow = f_model(fsel, eval_x[g]);
    if (L == 0) begin : g_comb
      assign eval_f[g] = fnow;
    end else begin : g_pipe
      logic [7:0] fpipe;
      always @(posedge clk) fpipe <= {fpipe[6:0], fnow};
      assign eval_f[g] = fpipe[L-1];
    end

    maj7_tt_sweeper #(.EVAL_LAT(L), .NIN(7)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start[g]),
      .abort         (abort[g]),
      .busy          (busy[g]),
      .eval_vld      (eval_vld[g]),
      .eval_x        (eval_x[g]),
      .eval_f        (eval_f[g]),
      .res_valid     (res_valid[g]),
      .res_ready     (res_ready[g]),
      .res_tt        (res_tt[g]),
      .res_ones      (res_ones[g]),
      .exp_tt        (exp_tt),
      .res_mismatch  (res_mismatch[g]),
      .res_first_bad (res_first_bad[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: every rising res_valid consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      if (res_valid[g] && !rv_prev[g]) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: inst %0d raised res_valid, required no result", g);
        end else begin
          e = sb_q.pop_front();
          chk("sb_inst", 128'(g), 128'(e.inst));
          chk("sb_tt", res_tt[g], e.tt);
          chk("sb_ones", 128'(res_ones[g]), 128'(e.ones));
          chk("sb_mismatch", 128'(res_mismatch[g]), 128'(e.mis));
          chk("sb_first_bad", 128'(res_first_bad[g]), 128'(e.fb));
        end
      end
    end
    rv_prev <= res_valid;
  end

  task automatic check_zero(input int g, input string tag);
    chk({tag, "_ctrl"}, 128'({busy[g], eval_vld[g], res_valid[g], res_mismatch[g]}), 128'(0));
    chk({tag, "_x"}, 128'({eval_x[g], res_first_bad[g], res_ones[g]}), 128'(0));
    chk({tag, "_tt"}, res_tt[g], 128'(0));
  endtask

  task automatic run_sweep(input int g, input int lat, input logic [1:0] fs,
                           input logic [127:0] ett, input logic [127:0] tt,
                           input logic [7:0] ones, input logic mis, input logic [6:0] fb,
                           input int hold);
    exp_t e;
    int n;
    bit seq_ok, stable;
    @(negedge clk);
    fsel   = fs;
    exp_tt = ett;
    e.inst = g; e.tt = tt; e.ones = ones; e.mis = mis; e.fb = fb;
    sb_q.push_back(e);
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    n = 0;
    seq_ok = 1'b1;
    while (!res_valid[g] && n < 400) begin
      if (!busy[g]) seq_ok = 1'b0;
      if (n < 128) begin
        if (!eval_vld[g] || eval_x[g] != 7'(n)) seq_ok = 1'b0;
      end else if (eval_vld[g] || eval_x[g] != 7'd0) seq_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("sweep_seq_i%0d", g), 128'(seq_ok), 128'(1));
    chk($sformatf("latency_i%0d", g), 128'(n), 128'(128 + lat));
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!res_valid[g] || !busy[g] || res_tt[g] !== tt || res_ones[g] !== ones ||
          res_mismatch[g] !== mis || res_first_bad[g] !== fb) stable = 1'b0;
    end
    if (hold > 0) chk($sformatf("hold_stable_i%0d", g), 128'(stable), 128'(1));
    res_ready[g] = 1'b1;
    @(posedge clk); #1;
    res_ready[g] = 1'b0;
    chk($sformatf("idle_after_ready_i%0d", g), 128'({busy[g], res_valid[g]}), 128'(0));
    chk($sformatf("idle_keep_tt_i%0d", g), res_tt[g], tt);
  endtask

  task automatic run_abort(input int g);
    int n;
    bit saw;
    @(negedge clk);
    fsel = F_MAJ;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    n = 0;
    while (eval_x[g] != 7'd50 && n < 200) begin
      @(posedge clk); #1;
      n++;
      start[g] = (n == 10);
    end
    start[g] = 1'b0;
    chk("abort_reached_idx50", 128'(n), 128'(50));
    abort[g] = 1'b1;
    @(posedge clk); #1;
    abort[g] = 1'b0;
    chk("abort_ctrl", 128'({busy[g], eval_vld[g], res_valid[g]}), 128'(0));
    chk("abort_x", 128'(eval_x[g]), 128'(0));
    saw = 1'b0;
    repeat (150) begin
      @(posedge clk); #1;
      if (res_valid[g] || busy[g]) saw = 1'b1;
    end
    chk("abort_quiet", 128'(saw), 128'(0));
  endtask

  task automatic run_reset(input int g);
    int n;
    @(negedge clk);
    fsel = F_MAJ;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    n = 0;
    while (eval_x[g] != 7'd90 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reset_reached_idx90", 128'(n), 128'(90));
    #2 rst_n = 1'b0;
    #1;
    check_zero(g, "midsweep_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] tt_bad;
    logic         exp_mis;
    logic [6:0]   exp_fb;
    rst_n     = 1'b1;
    start     = '0;
    abort     = '0;
    res_ready = '0;
    fsel      = F_MAJ;
    exp_tt    = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) check_zero(g, $sformatf("por_i%0d", g));
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, 2, F_MAJ,  TT_MAJ, TT_MAJ, 8'd64,  1'b0, 7'd0, 0);
    run_sweep(1, 0, F_ONE,  TT_ONE, TT_ONE, 8'h80,  1'b0, 7'd0, 0);
    run_sweep(1, 0, F_ZERO, '0,     '0,     8'd0,   1'b0, 7'd0, 0);
    run_sweep(2, 8, F_X6,   TT_X6,  TT_X6,  8'd64,  1'b0, 7'd0, 20);

    run_abort(0);
    run_sweep(0, 2, F_MAJ,  TT_MAJ, TT_MAJ, 8'd64,  1'b0, 7'd0, 0);

    tt_bad     = TT_MAJ;
    tt_bad[5]  = ~tt_bad[5];
    tt_bad[77] = ~tt_bad[77];
`ifdef TT_EXPECT_CMP_EN
    exp_mis = 1'b1;
    exp_fb  = 7'd5;
`else
    exp_mis = 1'b0;
    exp_fb  = 7'd0;
`endif
    run_sweep(0, 2, F_MAJ, tt_bad, TT_MAJ, 8'd64, exp_mis, exp_fb, 3);

    run_reset(0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
